// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - ALU memory-class codes, LSU state encodings and access-size classes
package lsu_pkg;

    localparam logic [5:0] ALU_ADD = 6'h00;
    localparam logic [5:0] ALU_LB  = 6'h10;
    localparam logic [5:0] ALU_LH  = 6'h11;
    localparam logic [5:0] ALU_LW  = 6'h12;
    localparam logic [5:0] ALU_LBU = 6'h13;
    localparam logic [5:0] ALU_LHU = 6'h14;
    localparam logic [5:0] ALU_SB  = 6'h18;
    localparam logic [5:0] ALU_SH  = 6'h19;
    localparam logic [5:0] ALU_SW  = 6'h1A;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ    = 2'd1,
        ST_WAIT_R = 2'd2,
        ST_FIN    = 2'd3
    } lsu_state_e;

    typedef enum logic [1:0] {
        SZ_NONE = 2'd0,
        SZ_BYTE = 2'd1,
        SZ_HALF = 2'd2,
        SZ_WORD = 2'd3
    } size_e;

    typedef struct packed {
        logic  is_mem;
        logic  is_load;
        logic  is_unsigned;
        size_e size;
    } op_info_t;

    function automatic op_info_t decode_op(input logic [5:0] code);
        op_info_t info;
        info = '{is_mem: 1'b0, is_load: 1'b0, is_unsigned: 1'b0, size: SZ_NONE};
        case (code)
            ALU_LB:  info = '{1'b1, 1'b1, 1'b0, SZ_BYTE};
            ALU_LH:  info = '{1'b1, 1'b1, 1'b0, SZ_HALF};
            ALU_LW:  info = '{1'b1, 1'b1, 1'b0, SZ_WORD};
            ALU_LBU: info = '{1'b1, 1'b1, 1'b1, SZ_BYTE};
            ALU_LHU: info = '{1'b1, 1'b1, 1'b1, SZ_HALF};
            ALU_SB:  info = '{1'b1, 1'b0, 1'b0, SZ_BYTE};
            ALU_SH:  info = '{1'b1, 1'b0, 1'b0, SZ_HALF};
            ALU_SW:  info = '{1'b1, 1'b0, 1'b0, SZ_WORD};
            default: info = '{1'b0, 1'b0, 1'b0, SZ_NONE};
        endcase
        return info;
    endfunction

endpackage

// File: rtl/lsu_if.sv
// rtl/lsu_if.sv - execute-stage, data-memory and writeback signals of the LSU
interface lsu_if #(
    parameter int ADDR_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [5:0]        in_alucode;
    logic [ADDR_W-1:0] in_addr;
    logic [31:0]       in_sdata;
    logic [4:0]        in_rd;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [3:0]        mem_wstrb;
    logic [31:0]       mem_wdata;
    logic              mem_gnt;
    logic              mem_rvalid;
    logic [31:0]       mem_rdata;

    logic              wb_valid;
    logic [4:0]        wb_rd;
    logic [31:0]       wb_data;
    logic              done;
    logic              misalign;

    modport master (
        input  in_valid, in_alucode, in_addr, in_sdata, in_rd,
        output in_ready,
        output mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata,
        output wb_valid, wb_rd, wb_data, done, misalign
    );

    modport slave (
        output in_valid, in_alucode, in_addr, in_sdata, in_rd,
        input  in_ready,
        input  mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
        output mem_gnt, mem_rvalid, mem_rdata,
        input  wb_valid, wb_rd, wb_data, done, misalign
    );
endinterface

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - byte-lane steering, strobes, load extension and misalignment check
module lsu_align
    import lsu_pkg::*;
(
    input  logic [5:0]  alucode,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] sdata,
    input  logic [31:0] rdata,
    output logic        is_mem,
    output logic        is_load,
    output logic        misalign,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata,
    output logic [31:0] ldata
);
    op_info_t    info;
    logic [31:0] lane;
    logic [3:0]  strb;

    assign info    = decode_op(alucode);
    assign is_mem  = info.is_mem;
    assign is_load = info.is_load;
    assign lane    = rdata >> {addr_lo, 3'b000};
    // Strobes only matter for stores; loads always present an all-zero mask.
    assign wstrb   = (info.is_mem && !info.is_load) ? strb : 4'b0000;

    always_comb begin
        misalign = 1'b0;
        strb     = 4'b0000;
        wdata    = 32'h0;
        ldata    = 32'h0;
        case (info.size)
            SZ_BYTE: begin
                strb  = 4'b0001 << addr_lo;
                wdata = {4{sdata[7:0]}};
                ldata = info.is_unsigned ? {24'h0, lane[7:0]} : {{24{lane[7]}}, lane[7:0]};
            end
            SZ_HALF: begin
                misalign = addr_lo[0];
                strb     = 4'b0011 << addr_lo;
                wdata    = {2{sdata[15:0]}};
                ldata    = info.is_unsigned ? {16'h0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
            end
            SZ_WORD: begin
                misalign = (addr_lo != 2'b00);
                strb     = 4'b1111;
                wdata    = sdata;
                ldata    = lane;
            end
            default: begin
                misalign = 1'b0;
            end
        endcase
    end
endmodule

// File: rtl/lsu.sv
// rtl/lsu.sv - load/store unit FSM: one outstanding word-wide memory transaction
module lsu
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic clk,
    input  logic rst_n,
    lsu_if.master bus
);
    lsu_state_e        state_q, state_d;
    logic [5:0]        code_q, code_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       sdata_q, sdata_d;
    logic [4:0]        rd_q, rd_d;
    logic              mis_q, mis_d;
    logic [31:0]       wb_data_q, wb_data_d;
    logic [4:0]        wb_rd_q, wb_rd_d;

    logic              idle, in_req, in_fin;
    logic [5:0]        a_code;
    logic [1:0]        a_lo;
    logic              a_is_mem, a_is_load, a_misalign;
    logic [3:0]        a_wstrb;
    logic [31:0]       a_wdata, a_ldata;

    assign idle   = (state_q == ST_IDLE);
    assign in_req = (state_q == ST_REQ);
    assign in_fin = (state_q == ST_FIN);

    // In IDLE the aligner classifies the offered op; afterwards it works on the latched one.
    assign a_code = idle ? bus.in_alucode : code_q;
    assign a_lo   = idle ? bus.in_addr[1:0] : addr_q[1:0];

    lsu_align u_align (
        .alucode  (a_code),
        .addr_lo  (a_lo),
        .sdata    (sdata_q),
        .rdata    (bus.mem_rdata),
        .is_mem   (a_is_mem),
        .is_load  (a_is_load),
        .misalign (a_misalign),
        .wstrb    (a_wstrb),
        .wdata    (a_wdata),
        .ldata    (a_ldata)
    );

    assign bus.in_ready  = idle;
    assign bus.mem_req   = in_req;
    assign bus.mem_we    = in_req && !a_is_load;
    assign bus.mem_addr  = in_req ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
    assign bus.mem_wstrb = in_req ? a_wstrb : 4'b0000;
    assign bus.mem_wdata = (in_req && !a_is_load) ? a_wdata : 32'h0;
    assign bus.done      = in_fin;
    assign bus.misalign  = in_fin && mis_q;
    assign bus.wb_valid  = in_fin && a_is_load && !mis_q;
    assign bus.wb_rd     = wb_rd_q;
    assign bus.wb_data   = wb_data_q;

    always_comb begin
        state_d   = state_q;
        code_d    = code_q;
        addr_d    = addr_q;
        sdata_d   = sdata_q;
        rd_d      = rd_q;
        mis_d     = mis_q;
        wb_data_d = wb_data_q;
        wb_rd_d   = wb_rd_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    code_d  = bus.in_alucode;
                    addr_d  = bus.in_addr;
                    sdata_d = bus.in_sdata;
                    rd_d    = bus.in_rd;
                    mis_d   = a_misalign;
                    state_d = (a_misalign || !a_is_mem) ? ST_FIN : ST_REQ;
                end
            end
            ST_REQ: begin
                if (bus.mem_gnt) begin
                    state_d = a_is_load ? ST_WAIT_R : ST_FIN;
                end
            end
            ST_WAIT_R: begin
                if (bus.mem_rvalid) begin
                    wb_data_d = a_ldata;
                    wb_rd_d   = rd_q;
                    state_d   = ST_FIN;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            code_q    <= '0;
            addr_q    <= '0;
            sdata_q   <= '0;
            rd_q      <= '0;
            mis_q     <= 1'b0;
            wb_data_q <= '0;
            wb_rd_q   <= '0;
        end else begin
            state_q   <= state_d;
            code_q    <= code_d;
            addr_q    <= addr_d;
            sdata_q   <= sdata_d;
            rd_q      <= rd_d;
            mis_q     <= mis_d;
            wb_data_q <= wb_data_d;
            wb_rd_q   <= wb_rd_d;
        end
    end
endmodule

// File: tb/tb_lsu.sv
// tb/tb_lsu.sv - directed and randomized bench for lsu against a byte-level reference model
module tb_lsu;
    import lsu_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    logic [31:0] last_wb = 32'h0;
    logic [7:0]  mem_b [0:63];

    lsu_if #(.ADDR_W(32)) bus ();
    lsu #(.ADDR_W(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int size_of(input logic [5:0] c);
        case (c)
            ALU_LB, ALU_LBU, ALU_SB: return 1;
            ALU_LH, ALU_LHU, ALU_SH: return 2;
            ALU_LW, ALU_SW:          return 4;
            default:                 return 0;
        endcase
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [31:0] sd, input int nb);
        logic [31:0] w;
        for (int i = 0; i < 4; i++) w[8*i +: 8] = sd[8*(i % nb) +: 8];
        return w;
    endfunction

    function automatic logic [31:0] exp_load(input logic [31:0] rdw, input int off, input int nb, input bit sx);
        logic [31:0] v, mask;
        v    = rdw >> (8 * off);
        mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 32'd1);
        v    = v & mask;
        if (sx && v[8*nb-1]) v = v | ~mask;
        return v;
    endfunction

    task automatic run_op(input logic [5:0] code, input logic [31:0] addr, input logic [31:0] sdata,
                          input logic [4:0] rd, input int gd, input int rvd, input logic [31:0] rdw);
        int nb, off;
        bit ld, sx, mis;
        logic [31:0] el, strb;
        nb   = size_of(code);
        ld   = (code == ALU_LB) || (code == ALU_LH) || (code == ALU_LW) || (code == ALU_LBU) || (code == ALU_LHU);
        sx   = (code == ALU_LB) || (code == ALU_LH);
        off  = int'(addr[1:0]);
        mis  = (nb != 0) && ((off % nb) != 0);
        strb = ld ? 32'h0 : (((32'd1 << nb) - 32'd1) << off);

        chk("idle_ready", bus.in_ready, 1);
        bus.in_valid = 1'b1; bus.in_alucode = code; bus.in_addr = addr; bus.in_sdata = sdata; bus.in_rd = rd;
        step();
        bus.in_valid = 1'b0; bus.in_alucode = 6'($urandom); bus.in_addr = $urandom;
        bus.in_sdata = $urandom; bus.in_rd = 5'($urandom);
        chk("busy_ready", bus.in_ready, 0);

        if (nb == 0 || mis) begin
            chk("nomem_done", bus.done, 1);
            chk("nomem_misalign", bus.misalign, mis);
            chk("nomem_req", bus.mem_req, 0);
            chk("nomem_wb", bus.wb_valid, 0);
            chk("nomem_hold_wbdata", bus.wb_data, last_wb);
        end else begin
            for (int k = 0; k <= gd; k++) begin
                chk("req", bus.mem_req, 1);
                chk("req_addr", bus.mem_addr, addr & 32'hFFFF_FFFC);
                chk("req_we", bus.mem_we, !ld);
                chk("req_wstrb", bus.mem_wstrb, strb);
                if (!ld) chk("req_wdata", bus.mem_wdata, exp_wdata(sdata, nb));
                chk("req_ready", bus.in_ready, 0);
                if (k < gd) begin
                    bus.mem_rvalid = 1'($urandom_range(0, 1));
                    bus.mem_rdata  = $urandom;
                end else begin
                    bus.mem_rvalid = 1'b0;
                    bus.mem_gnt    = 1'b1;
                end
                step();
            end
            bus.mem_gnt = 1'b0;
            bus.mem_rvalid = 1'b0;
            if (!ld) begin
                chk("st_done", bus.done, 1);
                chk("st_wb", bus.wb_valid, 0);
                chk("st_req", bus.mem_req, 0);
                chk("st_hold_wbdata", bus.wb_data, last_wb);
                for (int i = 0; i < nb; i++) mem_b[(int'(addr[5:0]) + i) % 64] = sdata[8*i +: 8];
            end else begin
                for (int k = 0; k <= rvd; k++) begin
                    chk("wait_req", bus.mem_req, 0);
                    chk("wait_done", bus.done, 0);
                    chk("wait_ready", bus.in_ready, 0);
                    if (k == rvd) begin
                        bus.mem_rvalid = 1'b1;
                        bus.mem_rdata  = rdw;
                    end
                    step();
                end
                bus.mem_rvalid = 1'b0;
                el = exp_load(rdw, off, nb, sx);
                chk("ld_wb_valid", bus.wb_valid, 1);
                chk("ld_wb_rd", bus.wb_rd, rd);
                chk("ld_wb_data", bus.wb_data, el);
                chk("ld_done", bus.done, 1);
                chk("ld_misalign", bus.misalign, 0);
                last_wb = el;
            end
        end
        step();
        chk("fin_ready", bus.in_ready, 1);
        chk("fin_done", bus.done, 0);
        chk("fin_wb", bus.wb_valid, 0);
        chk("fin_misalign", bus.misalign, 0);
    endtask

    function automatic logic [31:0] model_word(input logic [31:0] addr);
        int b;
        b = int'(addr[5:2]) * 4;
        return {mem_b[b+3], mem_b[b+2], mem_b[b+1], mem_b[b]};
    endfunction

    initial begin
        logic [5:0]  codes [0:8];
        logic [5:0]  c;
        logic [31:0] a;
        codes = '{ALU_LB, ALU_LH, ALU_LW, ALU_LBU, ALU_LHU, ALU_SB, ALU_SH, ALU_SW, ALU_ADD};
        for (int i = 0; i < 64; i++) mem_b[i] = 8'($urandom);
        bus.in_valid = 1'b0; bus.in_alucode = '0; bus.in_addr = '0; bus.in_sdata = '0; bus.in_rd = '0;
        bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;

        repeat (2) step();
        chk("rst_ready", bus.in_ready, 1);
        chk("rst_req", bus.mem_req, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_wb_valid", bus.wb_valid, 0);
        chk("rst_misalign", bus.misalign, 0);
        chk("rst_wb_data", bus.wb_data, 0);
        chk("rst_wstrb", bus.mem_wstrb, 0);
        rst_n = 1'b1;
        step();

        run_op(ALU_SB,  32'h0000_1003, 32'h0000_00A5, 5'd1, 0, 0, 32'h0);
        run_op(ALU_LB,  32'h0000_2001, 32'h0, 5'd2, 0, 0, 32'h1234_80FF);
        chk("plan_lb", bus.wb_data, 32'hFFFF_FF80);
        run_op(ALU_LBU, 32'h0000_2001, 32'h0, 5'd3, 0, 0, 32'h1234_80FF);
        chk("plan_lbu", bus.wb_data, 32'h0000_0080);
        run_op(ALU_LH,  32'h0000_2002, 32'h0, 5'd4, 0, 0, 32'h1234_80FF);
        chk("plan_lh", bus.wb_data, 32'h0000_1234);
        run_op(ALU_LW,  32'h0000_3000, 32'h0, 5'd5, 3, 2, 32'hDEAD_BEEF);
        chk("plan_lw", bus.wb_data, 32'hDEAD_BEEF);
        run_op(ALU_SW,  32'h0000_4002, 32'h1111_2222, 5'd6, 0, 0, 32'h0);
        run_op(ALU_LH,  32'h0000_4001, 32'h0, 5'd7, 0, 0, 32'h0);
        run_op(ALU_ADD, 32'h0000_5000, 32'h0, 5'd8, 0, 0, 32'h0);

        // Reset while the request is still pending.
        bus.in_valid = 1'b1; bus.in_alucode = ALU_LW; bus.in_addr = 32'h3000; bus.in_rd = 5'd9;
        step();
        bus.in_valid = 1'b0;
        chk("rreq_req_before", bus.mem_req, 1);
        rst_n = 1'b0;
        #1;
        chk("rreq_req_async", bus.mem_req, 0);
        chk("rreq_ready_async", bus.in_ready, 1);
        last_wb = 32'h0;
        step();
        rst_n = 1'b1;

        // Reset while waiting for read data, then a stale rvalid.
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        bus.mem_gnt = 1'b1;
        step();
        bus.mem_gnt = 1'b0;
        chk("rwait_ready_before", bus.in_ready, 0);
        rst_n = 1'b0;
        #1;
        chk("rwait_ready_async", bus.in_ready, 1);
        chk("rwait_req_async", bus.mem_req, 0);
        step();
        rst_n = 1'b1;
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hBAD0_BAD0;
        step();
        bus.mem_rvalid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            chk("stale_wb", bus.wb_valid, 0);
            chk("stale_done", bus.done, 0);
            chk("stale_wb_data", bus.wb_data, 0);
            step();
        end
        run_op(ALU_LW, 32'h0000_3000, 32'h0, 5'd10, 0, 1, 32'h0BAD_F00D);

        for (int n = 0; n < 60; n++) begin
            c = codes[$urandom_range(0, 8)];
            a = 32'h100 + $urandom_range(0, 63);
            run_op(c, a, $urandom, 5'($urandom), $urandom_range(0, 2), $urandom_range(0, 2), model_word(a));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
